am2901: RTL
===========

Name: am2901

Overview:
- 4-bit bipolar microprocessor slice, used as the datapath element of the ALU.
- Contains a 16x4 two-address register file, a Q working register and an 8-function ALU. Operand sources, function and destination/shift mode are selected by a 9-bit microinstruction.
- Drives active-low group generate/propagate into the look-ahead carry generator, and receives its carry-in from that generator's Cout outputs. Slices cascade via the RAM and Q shift lines.

Parameters:
- None. The slice is fixed at 4 bits; wider datapaths instantiate multiple slices.

Ports:
- clk  in  1  clock; all register-file and Q updates occur on the rising edge
- reset_n  in  1  asynchronous active-low reset
- I  in  9  microinstruction: [8:6] destination, [5:3] function, [2:0] source
- A  in  4  register-file read address A
- B  in  4  register-file read/write address B
- D  in  4  direct data input
- Cn  in  1  carry in, active high
- OE_n  in  1  Y output enable, active low
- RAM0_in, RAM3_in  in  1 each  shift-in to F LSB (up) / F MSB (down)
- Q0_in, Q3_in  in  1 each  shift-in to Q LSB (up) / Q MSB (down)
- Y  out  4  data output; 0 when OE_n=1
- Y_oe  out  1  = !OE_n, for external tristate/mux
- RAM0_out, RAM3_out, Q0_out, Q3_out  out  1 each  shift-out values
- RAM0_oe, RAM3_oe, Q0_oe, Q3_oe  out  1 each  shift-pin drive enables
- nG, nP  out  1 each  active-low group generate/propagate
- Cn4  out  1  carry out
- OVR  out  1  overflow
- F3  out  1  sign, = F[3]
- F_zero  out  1  1 when F==0

Behaviour:
- Reset: while reset_n=0, all 16 RAM words and Q are 0 and writes are suppressed. All outputs are combinational from inputs and these cleared registers. Deassertion is synchronised externally.
- Reads: RA=RAM[A] and RB=RAM[B], combinational. A==B is legal.
- Source I[2:0] (R,S): 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
- Function I[5:3]:
  - 0 ADD: R+S+Cn.
  - 1 SUBR: S+~R+Cn.
  - 2 SUBS: R+~S+Cn.
  - 3 OR; 4 AND; 5 NOTRS (~R&S); 6 EXOR; 7 EXNOR.
- Arithmetic flags (functions 0-2), with R' and S' the operands after any complement:
  - Gi=R'i&S'i, Pi=R'i|S'i.
  - nG = !(G3|P3G2|P3P2G1|P3P2P1G0); nP = !(P3&P2&P1&P0).
  - Cn4 = 5-bit sum bit 4; OVR = carry into bit3 XOR Cn4.
- Logic flags (functions 3-7): nG=1, nP=1, Cn4=0, OVR=0.
- F3 and F_zero follow F for every function.
- Destination I[8:6] (Y value / action on the rising edge):
  - 0 QREG: Y=F; Q<=F.
  - 1 NOP: Y=F; no write.
  - 2 RAMA: Y=RA; RAM[B]<=F.
  - 3 RAMF: Y=F; RAM[B]<=F.
  - 4 RAMQD: Y=F; RAM[B]<={RAM3_in,F[3:1]}; Q<={Q3_in,Q[3:1]}.
  - 5 RAMD: Y=F; RAM[B]<={RAM3_in,F[3:1]}.
  - 6 RAMQU: Y=F; RAM[B]<={F[2:0],RAM0_in}; Q<={Q[2:0],Q0_in}.
  - 7 RAMU: Y=F; RAM[B]<={F[2:0],RAM0_in}.
- Shift pins:
  - Down (4,5): RAM0_out=F[0], RAM0_oe=1. Destination 4 also drives Q0_out=Q[0], Q0_oe=1.
  - Up (6,7): RAM3_out=F[3], RAM3_oe=1. Destination 6 also drives Q3_out=Q[3], Q3_oe=1.
  - All other cases: the pin's oe=0 and its out=0.
  - Destinations 5 and 7 leave Q0_oe/Q3_oe=0.
- Read-during-write: A or B equal to the written address returns the pre-edge value in the write cycle. The new value is visible the cycle after the edge.
- Source operand Q is the pre-edge Q, so Q<=F with source AQ uses the old Q.
- Latency: outputs combinational, zero cycles. Register updates take effect at the next rising edge.

Test Plan:
- Reset then read: pulse reset_n low mid-cycle, then I=1_3_4 (NOP, OR, 0A), A=5 -> Y=0, F_zero=1; any prior RAM/Q contents cleared immediately.
- Load and add: I=3_0_7 (RAMF, ADD, DZ), D=9, B=2, Cn=0, edge; then I=1_0_1, A=2, B=2, Cn=1 -> Y=3 (9+9+1=19), Cn4=1, OVR=1, nG=0.
- Subtract and zero: RAM[1]=6, RAM[2]=6; I=1_2_1 (SUBS), A=1, B=2, Cn=1 -> Y=0, F_zero=1, Cn4=1, nP=0.
- Q double shift down: Q=0xA, RAM[3]=0x5, RAM3_in=1, Q3_in=0, I=4_0_3 (RAMQD, ADD, ZB), B=3, Cn=0 -> RAM0_out=1, Q0_out=0, both oe=1; after edge RAM[3]=0xA, Q=0x5.
- Up shift and RAMA: I=7_0_4, A=B=4, RAM[4]=0xC, RAM0_in=1 -> RAM3_out=1; after edge RAM[4]=0x9. Then I=2_0_7, D=3, A=4 -> Y=0x9 (RA, not F).
- Output enable and logic flags: OE_n=1 with I=1_6_5, D=0xF, RA=0xF -> Y=0, Y_oe=0, F_zero=1, nG=1, nP=1, Cn4=0, OVR=0.

Source files
------------

// File: rtl/am2901.sv
`default_nettype none
// ============================================================================
// Module   : am2901
// Purpose  : 4-bit microprocessor slice. A 16x4 two-port register file, a Q
//            working register and an 8-function ALU, all steered by a 9-bit
//            microinstruction (destination / function / source).
//            Outputs are purely combinational from the inputs and the stored
//            state. Stored state changes only on the rising clock edge.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   I[8:0]               [8:6] destination, [5:3] function, [2:0] source
//   A, B                 register-file read addresses (B is also the write address)
//   D                    direct data input
//   Cn                   carry in, active high
//   OE_n                 Y output enable, active low
//   RAM0_in, RAM3_in     shift-in values for the F shifter
//   Q0_in, Q3_in         shift-in values for the Q shifter
//   Y, Y_oe              data output (0 when disabled), enable = !OE_n
//   RAMx_out/oe, Qx_out/oe  shift-out values and their pin drive enables
//   nG, nP               active-low group generate / propagate
//   Cn4, OVR             carry out, signed overflow
//   F3, F_zero           sign of F, F == 0
// ============================================================================
module am2901 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [8:0] I,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [3:0] D,
   input  logic       Cn,
   input  logic       OE_n,
   input  logic       RAM0_in,
   input  logic       RAM3_in,
   input  logic       Q0_in,
   input  logic       Q3_in,
   output logic [3:0] Y,
   output logic       Y_oe,
   output logic       RAM0_out,
   output logic       RAM3_out,
   output logic       Q0_out,
   output logic       Q3_out,
   output logic       RAM0_oe,
   output logic       RAM3_oe,
   output logic       Q0_oe,
   output logic       Q3_oe,
   output logic       nG,
   output logic       nP,
   output logic       Cn4,
   output logic       OVR,
   output logic       F3,
   output logic       F_zero
);

   localparam logic [2:0] DST_QREG  = 3'd0;
   localparam logic [2:0] DST_NOP   = 3'd1;
   localparam logic [2:0] DST_RAMA  = 3'd2;
   localparam logic [2:0] DST_RAMF  = 3'd3;
   localparam logic [2:0] DST_RAMQD = 3'd4;
   localparam logic [2:0] DST_RAMD  = 3'd5;
   localparam logic [2:0] DST_RAMQU = 3'd6;
   localparam logic [2:0] DST_RAMU  = 3'd7;

   logic [3:0] ram_q [16];
   logic [3:0] ram_d [16];
   logic [3:0] q_q;
   logic [3:0] q_d;

   logic [2:0] dst;
   logic [2:0] fnc;
   logic [2:0] src;

   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] r_opd;
   logic [3:0] s_opd;
   logic [3:0] r_alu;
   logic [3:0] s_alu;
   logic [4:0] sum5;
   logic [3:0] sum_lo;
   logic [3:0] g_bit;
   logic [3:0] p_bit;
   logic [3:0] f;
   logic       arith;
   logic [3:0] y_int;

   assign dst = I[8:6];
   assign fnc = I[5:3];
   assign src = I[2:0];

   // Reads see the pre-edge contents; a write to the same address appears
   // only after the edge.
   assign ra = ram_q[A];
   assign rb = ram_q[B];

   // Operand source selection
   always_comb begin
      r_opd = 4'h0;
      s_opd = 4'h0;
      case (src)
         3'd0: begin r_opd = ra;   s_opd = q_q;  end
         3'd1: begin r_opd = ra;   s_opd = rb;   end
         3'd2: begin r_opd = 4'h0; s_opd = q_q;  end
         3'd3: begin r_opd = 4'h0; s_opd = rb;   end
         3'd4: begin r_opd = 4'h0; s_opd = ra;   end
         3'd5: begin r_opd = D;    s_opd = ra;   end
         3'd6: begin r_opd = D;    s_opd = q_q;  end
         default: begin r_opd = D; s_opd = 4'h0; end
      endcase
   end

   // Subtraction is done as an addition of the complemented operand, so the
   // flags are always derived from a single adder on (r_alu, s_alu).
   assign arith = (fnc == 3'd0) || (fnc == 3'd1) || (fnc == 3'd2);
   assign r_alu = (fnc == 3'd1) ? ~r_opd : r_opd;
   assign s_alu = (fnc == 3'd2) ? ~s_opd : s_opd;

   assign sum5   = {1'b0, r_alu} + {1'b0, s_alu} + {4'b0000, Cn};
   assign sum_lo = {1'b0, r_alu[2:0]} + {1'b0, s_alu[2:0]} + {3'b000, Cn};
   assign g_bit  = r_alu & s_alu;
   assign p_bit  = r_alu | s_alu;

   always_comb begin
      f = 4'h0;
      case (fnc)
         3'd0, 3'd1, 3'd2: f = sum5[3:0];
         3'd3:             f = r_opd | s_opd;
         3'd4:             f = r_opd & s_opd;
         3'd5:             f = ~r_opd & s_opd;
         3'd6:             f = r_opd ^ s_opd;
         default:          f = ~(r_opd ^ s_opd);
      endcase
   end

   // Logic functions force the carry-chain flags to their inactive levels.
   always_comb begin
      nG  = 1'b1;
      nP  = 1'b1;
      Cn4 = 1'b0;
      OVR = 1'b0;
      if (arith) begin
         nG  = ~(g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1]) |
                 (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]));
         nP  = ~(&p_bit);
         Cn4 = sum5[4];
         OVR = sum_lo[3] ^ sum5[4];
      end
   end

   assign F3     = f[3];
   assign F_zero = (f == 4'h0);

   assign y_int = (dst == DST_RAMA) ? ra : f;
   assign Y     = OE_n ? 4'h0 : y_int;
   assign Y_oe  = ~OE_n;

   // Shift pins: the LSB leaves on down shifts, the MSB leaves on up shifts.
   always_comb begin
      RAM0_out = 1'b0;
      RAM0_oe  = 1'b0;
      RAM3_out = 1'b0;
      RAM3_oe  = 1'b0;
      Q0_out   = 1'b0;
      Q0_oe    = 1'b0;
      Q3_out   = 1'b0;
      Q3_oe    = 1'b0;
      case (dst)
         DST_RAMQD: begin
            RAM0_out = f[0];
            RAM0_oe  = 1'b1;
            Q0_out   = q_q[0];
            Q0_oe    = 1'b1;
         end
         DST_RAMD: begin
            RAM0_out = f[0];
            RAM0_oe  = 1'b1;
         end
         DST_RAMQU: begin
            RAM3_out = f[3];
            RAM3_oe  = 1'b1;
            Q3_out   = q_q[3];
            Q3_oe    = 1'b1;
         end
         DST_RAMU: begin
            RAM3_out = f[3];
            RAM3_oe  = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state for the register file and Q
   always_comb begin
      for (int k = 0; k < 16; k++) begin
         ram_d[k] = ram_q[k];
      end
      q_d = q_q;
      case (dst)
         DST_QREG: q_d = f;
         DST_NOP: ;
         DST_RAMA, DST_RAMF: ram_d[B] = f;
         DST_RAMQD: begin
            ram_d[B] = {RAM3_in, f[3:1]};
            q_d      = {Q3_in, q_q[3:1]};
         end
         DST_RAMD: ram_d[B] = {RAM3_in, f[3:1]};
         DST_RAMQU: begin
            ram_d[B] = {f[2:0], RAM0_in};
            q_d      = {q_q[2:0], Q0_in};
         end
         default: ram_d[B] = {f[2:0], RAM0_in};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 16; k++) begin
            ram_q[k] <= 4'h0;
         end
         q_q <= 4'h0;
      end else begin
         for (int k = 0; k < 16; k++) begin
            ram_q[k] <= ram_d[k];
         end
         q_q <= q_d;
      end
   end

endmodule
`default_nettype wire
